// File: rtl/uart_pkg.sv
// Shared UART definitions: register map, status bit positions and the
// scheduler state encoding. ST_CLEAR is only present when the optional
// poll-timeout recovery (UART_SCHED_TIMEOUT_EN) is compiled in.
package uart_pkg;

    localparam logic [31:0] UART_CTRL   = 32'h0000_0000;
    localparam logic [31:0] UART_STATUS = 32'h0000_0004;
    localparam logic [31:0] UART_BAUD   = 32'h0000_0008;
    localparam logic [31:0] UART_TXDATA = 32'h0000_000C;
    localparam logic [31:0] UART_RXDATA = 32'h0000_0010;

    localparam int TX_BUSY = 0;
    localparam int RX_DONE = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_SETTLE = 3'd2,
`ifdef UART_SCHED_TIMEOUT_EN
        ST_CLEAR  = 3'd4,
`endif
        ST_POLL   = 3'd3
    } sched_state_e;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester handshake plus UART register bus for the TX scheduler.
// slave = scheduler side, master = requesters/UART side.
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0][7:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    wmem;
    logic [31:0]             A_UART;
    logic [31:0]             Di;
    logic [31:0]             Do_Uart;

    modport slave (
        input  req_valid, req_data, Do_Uart,
        output req_ready, wmem, A_UART, Di
    );

    modport master (
        output req_valid, req_data, Do_Uart,
        input  req_ready, wmem, A_UART, Di
    );
endinterface

// File: rtl/uart_rr_arb.sv
// Combinational round-robin arbiter: searches the request mask starting at
// ptr+1 (wrapping) and returns a one-hot grant plus its index.
module uart_rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [2:0]         idx,
    output logic               any
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [3:0]           off;
    logic [3:0]           sum;

    // rot[j] is the request at position (ptr+1+j) mod NUM_REQ; ptr < NUM_REQ
    // keeps the shift within the doubled vector.
    assign dbl = {req, req} >> (4'(ptr) + 4'd1);
    assign rot = dbl[NUM_REQ-1:0];
    assign any = |req;

    // First set bit of the rotated mask, then map back to an absolute index.
    always_comb begin
        off = 4'd0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) off = 4'(j);
        end
        sum = 4'(ptr) + 4'd1 + off;
        if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
        idx = sum[2:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = any && (sum == 4'(i));
        end
    end
endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler in front of a polled UART transmitter.
// Each grant writes TXDATA, waits one settle cycle, then polls STATUS until
// TX_BUSY drops. Optional macro UART_SCHED_TIMEOUT_EN adds a poll timeout
// that clears the UART status and raises a sticky timeout_err.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic             CLK,
    input  logic             RESET,
    uart_tx_sched_if.slave   bus,
    output logic             sched_busy,
    output logic [2:0]       grant_id,
    output logic             timeout_err
);
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_chk
        $error("uart_tx_sched: parameter out of range");
    end

    sched_state_e       state_q, state_d;
    logic [2:0]         grant_id_q, grant_id_d;
    logic [7:0]         byte_q, byte_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [2:0]         arb_idx;
    logic               arb_any;

    // Only the TX_BUSY bit of STATUS matters here.
    logic unused_status;
    assign unused_status = ^bus.Do_Uart[31:1];

    uart_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req (bus.req_valid),
        .ptr (grant_id_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;
`endif

    // State and datapath registers; reset abandons any byte in flight.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            grant_id_q <= 3'(NUM_REQ - 1);
            byte_q     <= 8'h00;
            gnt_q      <= '0;
`ifdef UART_SCHED_TIMEOUT_EN
            cnt_q      <= '0;
            terr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            byte_q     <= byte_d;
            gnt_q      <= gnt_d;
`ifdef UART_SCHED_TIMEOUT_EN
            cnt_q      <= cnt_d;
            terr_q     <= terr_d;
`endif
        end
    end

    // Next-state and bus outputs; idle bus points at STATUS with no write.
    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        byte_d        = byte_q;
        gnt_d         = gnt_q;
        bus.wmem      = 1'b0;
        bus.A_UART    = UART_STATUS;
        bus.Di        = 32'h0;
        bus.req_ready = '0;
`ifdef UART_SCHED_TIMEOUT_EN
        cnt_d         = cnt_q;
        terr_d        = terr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    // Byte and index are captured here so a requester that
                    // drops valid early still gets its byte sent.
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (arb_gnt[i]) byte_d = bus.req_data[i];
                    end
                    grant_id_d = arb_idx;
                    gnt_d      = arb_gnt;
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                bus.wmem      = 1'b1;
                bus.A_UART    = UART_TXDATA;
                bus.Di        = {24'h0, byte_q};
                bus.req_ready = gnt_q;
                state_d       = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Busy bit is only valid one cycle after the TXDATA write.
                state_d = ST_POLL;
`ifdef UART_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_POLL: begin
                if (!bus.Do_Uart[TX_BUSY]) begin
                    state_d = ST_IDLE;
`ifdef UART_SCHED_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_CLEAR;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
`ifdef UART_SCHED_TIMEOUT_EN
            ST_CLEAR: begin
                bus.wmem   = 1'b1;
                bus.A_UART = UART_STATUS;
                bus.Di     = 32'h0;
                state_d    = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign sched_busy = (state_q != ST_IDLE);
    assign grant_id   = grant_id_q;
`ifdef UART_SCHED_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: stimulus pushes expected bus writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_uart_tx_sched;
    localparam int N = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  rdy;
        int          gap;
    } wr_t;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic sched_busy;
    logic [2:0] grant_id;
    logic timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nwr = 0;
    int last_wr = 0;
    wr_t exp_q[$];

    int busy_cnt = 0;
    int busy_len = 0;
    bit stuck = 0;

    uart_tx_sched_if #(.NUM_REQ(N)) bus ();

    uart_tx_sched #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus),
        .sched_busy(sched_busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // UART model: TXDATA write starts a busy window of busy_len cycles.
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) busy_cnt <= 0;
        else if (bus.wmem && bus.A_UART == 32'h0C) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.Do_Uart = (bus.A_UART == 32'h04) ?
                         {31'h0, (stuck || busy_cnt != 0)} : 32'h0;

    // Monitor: every bus write must match the head of the expected queue.
    always @(negedge CLK) begin
        wr_t e;
        if (RESET) begin
            if (bus.wmem) begin
                nwr++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%h data=%h rdy=%b", bus.A_UART, bus.Di, bus.req_ready);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.A_UART !== e.addr || bus.Di !== e.data || bus.req_ready !== e.rdy) begin
                        errors++;
                        $display("FAIL write got addr=%h data=%h rdy=%b expected addr=%h data=%h rdy=%b",
                                 bus.A_UART, bus.Di, bus.req_ready, e.addr, e.data, e.rdy);
                    end
                    if (e.gap != 0) begin
                        checks++;
                        if (cyc - last_wr != e.gap) begin
                            errors++;
                            $display("FAIL write_gap got %0d expected %0d", cyc - last_wr, e.gap);
                        end
                    end
                end
                last_wr = cyc;
            end else if (bus.req_ready != 0) begin
                checks++;
                errors++;
                $display("FAIL ready_without_write rdy=%b expected 0000", bus.req_ready);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] r, input int g);
        wr_t e;
        e.addr = a; e.data = d; e.rdy = r; e.gap = g;
        exp_q.push_back(e);
    endtask

    task automatic wait_writes(input int n, input int bound);
        int k = 0;
        while (nwr < n && k < bound) begin
            @(negedge CLK);
            k++;
        end
        if (nwr < n) begin
            checks++; errors++;
            $display("FAIL wait_writes got %0d expected %0d", nwr, n);
        end
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while (sched_busy && n < bound) begin
            @(negedge CLK);
            n++;
        end
        if (sched_busy) begin
            checks++; errors++;
            $display("FAIL wait_idle got busy=1 expected 0 after %0d cycles", bound);
        end
    endtask

    initial begin
        int n;
        bus.req_valid = '0;
        bus.req_data  = '0;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_wmem", 32'(bus.wmem), 0);
        check("rst_addr", bus.A_UART, 32'h04);
        check("rst_di", bus.Di, 0);
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_busy", 32'(sched_busy), 0);
        check("rst_grant", 32'(grant_id), 3);
        check("rst_terr", 32'(timeout_err), 0);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);

        // Single byte with a 100-cycle busy UART
        busy_len = 100;
        push(32'h0C, 32'h55, 4'b0001, 0);
        bus.req_data[0] = 8'h55;
        bus.req_valid = 4'b0001;
        wait_writes(1, 20);
        bus.req_valid = '0;
        wait_idle(300, n);
        checks++;
        if (n < 98 || n > 105) begin
            errors++;
            $display("FAIL poll_len got %0d expected 98..105", n);
        end
        check("single_grant", 32'(grant_id), 0);

        // Reset mid-POLL abandons the transfer
        push(32'h0C, 32'h77, 4'b0100, 0);
        bus.req_data[2] = 8'h77;
        bus.req_valid = 4'b0100;
        wait_writes(2, 20);
        bus.req_valid = '0;
        repeat (10) @(negedge CLK);
        check("poll_busy", 32'(sched_busy), 1);
        RESET = 1'b0;
        @(posedge CLK); #1;
        check("mr_busy", 32'(sched_busy), 0);
        check("mr_wmem", 32'(bus.wmem), 0);
        check("mr_addr", bus.A_UART, 32'h04);
        check("mr_ready", 32'(bus.req_ready), 0);
        check("mr_grant", 32'(grant_id), 3);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);

        // All requesters valid, UART free: 0,1,2,3,0 at 4-cycle spacing
        busy_len = 0;
        for (int i = 0; i < 4; i++) bus.req_data[i] = 8'hA0 + 8'(i);
        push(32'h0C, 32'hA0, 4'b0001, 0);
        push(32'h0C, 32'hA1, 4'b0010, 4);
        push(32'h0C, 32'hA2, 4'b0100, 4);
        push(32'h0C, 32'hA3, 4'b1000, 4);
        push(32'h0C, 32'hA0, 4'b0001, 4);
        bus.req_valid = 4'b1111;
        wait_writes(nwr + 5, 60);
        bus.req_valid = '0;
        wait_idle(20, n);
        check("all_grant", 32'(grant_id), 0);

        // Fairness between two permanently valid requesters
        busy_len = 3;
        bus.req_data[1] = 8'hB1;
        bus.req_data[2] = 8'hB2;
        push(32'h0C, 32'hB1, 4'b0010, 0);
        push(32'h0C, 32'hB2, 4'b0100, 0);
        push(32'h0C, 32'hB1, 4'b0010, 0);
        push(32'h0C, 32'hB2, 4'b0100, 0);
        bus.req_valid = 4'b0110;
        wait_writes(nwr + 4, 80);
        bus.req_valid = '0;
        wait_idle(30, n);
        check("fair_grant", 32'(grant_id), 2);

        // Busy stuck high
        stuck = 1;
        bus.req_data[3] = 8'h33;
        push(32'h0C, 32'h33, 4'b1000, 0);
`ifdef UART_SCHED_TIMEOUT_EN
        push(32'h04, 32'h00, 4'b0000, 18);
`endif
        bus.req_valid = 4'b1000;
        wait_writes(nwr + 1, 20);
        bus.req_valid = '0;
`ifdef UART_SCHED_TIMEOUT_EN
        wait_idle(60, n);
        check("to_terr", 32'(timeout_err), 1);
        stuck = 0;
        repeat (5) @(negedge CLK);
        check("to_terr_sticky", 32'(timeout_err), 1);
        check("to_idle", 32'(sched_busy), 0);
`else
        repeat (40) @(negedge CLK);
        check("nt_busy", 32'(sched_busy), 1);
        check("nt_addr", bus.A_UART, 32'h04);
        check("nt_terr", 32'(timeout_err), 0);
        stuck = 0;
        wait_idle(10, n);
`endif

        repeat (5) @(negedge CLK);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
